// File: rtl/inst_encoder_if.sv
// inst_encoder_if: field-input and encoded-word-output handshake bundle for inst_encoder.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err
  );
  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: RV32I field-to-word encoder with range checks, address tagging and 2-entry output FIFO.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  inst_encoder_if.slave bus,
  input  logic          clr_err,
  output logic [7:0]    err_cnt
);
  typedef enum logic {RUN, HALT} state_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } entry_t;
  state_t      state_q, state_d;
  entry_t      mem_q [2];
  entry_t      mem_d [2];
  entry_t      new_e;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [6:0]  op, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm, inst;
  logic        is_r, is_i, is_sh, is_s, is_b, is_u, is_j;
  logic        i_ok, b_ok, j_ok, err, push, pop;
  assign op  = bus.in_opcode;
  assign f7  = bus.in_funct7;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign f3  = bus.in_funct3;
  assign imm = bus.in_imm;
  always_comb begin
    is_r  = op == 7'b0110011;
    is_sh = op == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101);
    is_i  = op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111;
    is_s  = op == 7'b0100011;
    is_b  = op == 7'b1100011;
    is_u  = op == 7'b0110111 || op == 7'b0010111;
    is_j  = op == 7'b1101111;
    i_ok  = &imm[31:11] || ~|imm[31:11];
    b_ok  = (&imm[31:12] || ~|imm[31:12]) && !imm[0];
    j_ok  = (&imm[31:20] || ~|imm[31:20]) && !imm[0];
    inst  = is_r  ? {f7, rs2, rs1, f3, rd, op} :
            is_sh ? {f7, imm[4:0], rs1, f3, rd, op} :
            is_i  ? {imm[11:0], rs1, f3, rd, op} :
            is_s  ? {imm[11:5], rs2, rs1, f3, imm[4:0], op} :
            is_b  ? {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op} :
            is_u  ? {imm[31:12], rd, op} :
            is_j  ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, op} : 32'h0;
    err   = is_r  ? 1'b0 :
            is_sh ? |imm[31:5] :
            (is_i || is_s) ? !i_ok :
            is_b  ? !b_ok :
            is_u  ? |imm[11:0] :
            is_j  ? !j_ok : 1'b1;
  end
  assign bus.in_ready  = cnt_q != 2'd2 && state_q == RUN;
  assign bus.out_valid = cnt_q != 2'd0;
  assign bus.out_inst  = bus.out_valid ? mem_q[rd_q].inst : 32'h0;
  assign bus.out_addr  = bus.out_valid ? mem_q[rd_q].addr : 32'h0;
  assign bus.out_err   = bus.out_valid ? mem_q[rd_q].err : 1'b0;
  assign err_cnt       = err_cnt_q;
  always_comb begin
    push      = bus.in_valid && bus.in_ready;
    pop       = bus.out_valid && bus.out_ready;
    new_e     = {err ? 32'h0000_0013 : inst, addr_q, err};
    mem_d[0]  = (push && !wr_q) ? new_e : mem_q[0];
    mem_d[1]  = (push && wr_q) ? new_e : mem_q[1];
    wr_d      = wr_q ^ push;
    rd_d      = rd_q ^ pop;
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    addr_d    = push ? addr_q + 32'd4 : addr_q;
    err_cnt_d = (push && err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    state_d   = (state_q == RUN && push && err && STOP_ON_ERR) ? HALT :
                (state_q == HALT && clr_err) ? RUN : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      mem_q     <= '{default: '0};
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= 2'd0;
      addr_q    <= BASE_ADDR;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule
